// File: rtl/frog_collision_ctrl.sv
// Per-frame frog/car collision and goal controller; owns lives, level and game-over state.
// Latency: hit/goal pulses appear NUM_CARS+1 clocks after the edge that samples i_frame_tick.
// Backpressure: none; frame ticks arriving while busy or in game-over are dropped, never queued.
module frog_collision_ctrl #(
  parameter int          NUM_CARS      = 4,
  parameter int          CAR_W         = 32,
  parameter int          CAR_H         = 32,
  parameter int          FROG_W        = 32,
  parameter int          FROG_H        = 32,
  parameter int          START_LIVES   = 3,
  parameter int          MAX_LEVEL     = 9,
  parameter int          GOAL_Y        = 0,
  parameter logic [23:0] INVULN_CYCLES = 24'd12_500_000
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_frame_tick,
  input  logic [10*NUM_CARS-1:0]   i_carX_bus,
  input  logic [10*NUM_CARS-1:0]   i_carY_bus,
  input  logic [9:0]               i_frogX,
  input  logic [9:0]               i_frogY,
  output logic                     o_collision,
  output logic                     o_level_up,
  output logic                     o_frog_reset,
  output logic [3:0]               o_level,
  output logic [1:0]               o_lives,
  output logic                     o_game_over,
  output logic                     o_busy
);

  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_RESOLVE,
    S_HOLDOFF,
    S_GAME_OVER
  } state_t;

  state_t       state_q, state_d;
  logic [9:0]   car_x_q [NUM_CARS];
  logic [9:0]   car_x_d [NUM_CARS];
  logic [9:0]   car_y_q [NUM_CARS];
  logic [9:0]   car_y_d [NUM_CARS];
  logic [9:0]   frog_x_q, frog_x_d;
  logic [9:0]   frog_y_q, frog_y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic         hit_q, hit_d;
  logic [23:0]  holdoff_q, holdoff_d;
  logic [3:0]   level_q, level_d;
  logic [1:0]   lives_q, lives_d;
  logic         game_over_q, game_over_d;
  logic         collision_q, collision_d;
  logic         level_up_q, level_up_d;
  logic         frog_reset_q, frog_reset_d;

  // Box overlap of the snapshot frog against the car currently addressed by idx.
  // Operands are widened to 11 bits so right/bottom edges near 1023 cannot wrap.
  logic [10:0] cx, cy, fx, fy;
  logic        overlap;

  // Axis-aligned overlap test for the car being scanned this cycle.
  always_comb begin
    cx = {1'b0, car_x_q[idx_q]};
    cy = {1'b0, car_y_q[idx_q]};
    fx = {1'b0, frog_x_q};
    fy = {1'b0, frog_y_q};
    overlap = (cx < fx + 11'(FROG_W)) && (fx < cx + 11'(CAR_W)) &&
              (cy < fy + 11'(FROG_H)) && (fy < cy + 11'(CAR_H));
  end

  // Next-state and registered-output logic for the scan/resolve controller.
  always_comb begin
    state_d      = state_q;
    car_x_d      = car_x_q;
    car_y_d      = car_y_q;
    frog_x_d     = frog_x_q;
    frog_y_d     = frog_y_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    holdoff_d    = holdoff_q;
    level_d      = level_q;
    lives_d      = lives_q;
    game_over_d  = game_over_q;
    collision_d  = 1'b0;
    level_up_d   = 1'b0;
    frog_reset_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_frame_tick) begin
          for (int i = 0; i < NUM_CARS; i++) begin
            car_x_d[i] = i_carX_bus[10*i +: 10];
            car_y_d[i] = i_carY_bus[10*i +: 10];
          end
          frog_x_d = i_frogX;
          frog_y_d = i_frogY;
          hit_d    = 1'b0;
          idx_d    = '0;
          state_d  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (overlap) begin
          hit_d = 1'b1;
        end
        if (idx_q == IDX_W'(NUM_CARS - 1)) begin
          idx_d   = '0;
          state_d = S_RESOLVE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_RESOLVE: begin
        if (hit_q) begin
          // A hit wins over reaching the goal in the same frame.
          collision_d  = 1'b1;
          frog_reset_d = 1'b1;
          if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
          if (lives_q <= 2'd1) begin
            game_over_d = 1'b1;
            state_d     = S_GAME_OVER;
          end else begin
            holdoff_d = INVULN_CYCLES;
            state_d   = S_HOLDOFF;
          end
        end else if (frog_y_q <= 10'(GOAL_Y)) begin
          level_up_d   = 1'b1;
          frog_reset_d = 1'b1;
          if (level_q < 4'(MAX_LEVEL)) begin
            level_d = level_q + 4'd1;
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HOLDOFF: begin
        // Invulnerability window; ticks are ignored until it expires.
        if (holdoff_q <= 24'd1) begin
          holdoff_d = '0;
          state_d   = S_IDLE;
        end else begin
          holdoff_d = holdoff_q - 24'd1;
        end
      end

      S_GAME_OVER: begin
        state_d = S_GAME_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < NUM_CARS; i++) begin
        car_x_q[i] <= '0;
        car_y_q[i] <= '0;
      end
      frog_x_q     <= '0;
      frog_y_q     <= '0;
      idx_q        <= '0;
      hit_q        <= 1'b0;
      holdoff_q    <= '0;
      level_q      <= 4'd1;
      lives_q      <= 2'(START_LIVES);
      game_over_q  <= 1'b0;
      collision_q  <= 1'b0;
      level_up_q   <= 1'b0;
      frog_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < NUM_CARS; i++) begin
        car_x_q[i] <= car_x_d[i];
        car_y_q[i] <= car_y_d[i];
      end
      frog_x_q     <= frog_x_d;
      frog_y_q     <= frog_y_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      holdoff_q    <= holdoff_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      game_over_q  <= game_over_d;
      collision_q  <= collision_d;
      level_up_q   <= level_up_d;
      frog_reset_q <= frog_reset_d;
    end
  end

  assign o_collision  = collision_q;
  assign o_level_up   = level_up_q;
  assign o_frog_reset = frog_reset_q;
  assign o_level      = level_q;
  assign o_lives      = lives_q;
  assign o_game_over  = game_over_q;
  assign o_busy       = (state_q == S_SCAN) || (state_q == S_RESOLVE) || (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Bench for frog_collision_ctrl: directed scenarios plus randomized frames against a frame-level model.
// Expected results are queued per accepted tick and checked by a cycle monitor.
// Ticks dropped by the DUT are predicted by the model, so any stray pulse is flagged.
module tb_frog_collision_ctrl;

  localparam int NC  = 4;
  localparam int INV = 16;
  localparam int LAT = NC + 1;

  logic            clk = 1'b0;
  logic            i_Rst = 1'b1;
  logic            i_frame_tick = 1'b0;
  logic [10*NC-1:0] i_carX_bus = '0;
  logic [10*NC-1:0] i_carY_bus = '0;
  logic [9:0]      i_frogX = '0;
  logic [9:0]      i_frogY = '0;
  logic            o_collision, o_level_up, o_frog_reset, o_game_over, o_busy;
  logic [3:0]      o_level;
  logic [1:0]      o_lives;

  frog_collision_ctrl #(
    .NUM_CARS(NC), .CAR_W(32), .CAR_H(32), .FROG_W(32), .FROG_H(32),
    .START_LIVES(3), .MAX_LEVEL(9), .GOAL_Y(0), .INVULN_CYCLES(24'(INV))
  ) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_frame_tick(i_frame_tick),
    .i_carX_bus(i_carX_bus), .i_carY_bus(i_carY_bus),
    .i_frogX(i_frogX), .i_frogY(i_frogY),
    .o_collision(o_collision), .o_level_up(o_level_up), .o_frog_reset(o_frog_reset),
    .o_level(o_level), .o_lives(o_lives), .o_game_over(o_game_over), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int due;
    int col;
    int lup;
    int lives;
    int level;
    int go;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state
  int car_x[NC];
  int car_y[NC];
  int frog_x, frog_y;
  int m_lives = 3, m_level = 1, m_go = 0;
  int m_busy_lo = -1, m_busy_hi = -2, m_free = 0;
  int cur_lives = 3, cur_level = 1, cur_go = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_pos();
    for (int i = 0; i < NC; i++) begin
      i_carX_bus[10*i +: 10] = 10'(car_x[i]);
      i_carY_bus[10*i +: 10] = 10'(car_y[i]);
    end
    i_frogX = 10'(frog_x);
    i_frogY = 10'(frog_y);
  endtask

  function automatic int any_hit();
    int h = 0;
    for (int i = 0; i < NC; i++) begin
      if (car_x[i] < frog_x + 32 && frog_x < car_x[i] + 32 &&
          car_y[i] < frog_y + 32 && frog_y < car_y[i] + 32)
        h = 1;
    end
    return h;
  endfunction

  // Drive one tick with the current positions; the model decides whether it is accepted.
  task automatic issue_tick();
    int k;
    exp_t e;
    int hit, goal;
    apply_pos();
    k = edge_cnt + 1;
    i_frame_tick = 1'b1;
    if (m_go == 0 && k >= m_free) begin
      hit  = any_hit();
      goal = (frog_y <= 0) ? 1 : 0;
      e.due = k + LAT;
      e.col = hit;
      e.lup = (!hit && goal) ? 1 : 0;
      if (hit) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_go = 1;
      end else if (goal && m_level < 9) begin
        m_level = m_level + 1;
      end
      e.lives = m_lives;
      e.level = m_level;
      e.go    = m_go;
      sb_q.push_back(e);
      m_busy_lo = k;
      m_busy_hi = k + LAT - 1 + ((hit && !m_go) ? INV : 0);
      m_free    = m_busy_hi + 2;
    end
    step(1);
    i_frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    sb_q.delete();
    m_lives = 3; m_level = 1; m_go = 0;
    m_busy_lo = -1; m_busy_hi = -2; m_free = 0;
    cur_lives = 3; cur_level = 1; cur_go = 0;
    step(1);
    i_Rst = 1'b0;
  endtask

  task automatic wait_free();
    int guard = 0;
    while (m_go == 0 && edge_cnt + 1 < m_free && guard < 200) begin
      step(1);
      guard++;
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < NC; i++) begin
      i_carX_bus[10*i +: 10] = 10'($urandom_range(0, 1023));
      i_carY_bus[10*i +: 10] = 10'($urandom_range(0, 1023));
    end
    i_frogX = 10'($urandom_range(0, 1023));
    i_frogY = 10'($urandom_range(0, 1023));
  endtask

  function automatic int near(input int base);
    int v = base + $urandom_range(0, 80) - 40;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  // Monitor: every cycle compare pulses against the queue head and status against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!i_Rst) begin
      chk("busy", int'(o_busy), (edge_cnt >= m_busy_lo && edge_cnt <= m_busy_hi) ? 1 : 0);
      if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
        e = sb_q.pop_front();
        chk("collision", int'(o_collision), e.col);
        chk("level_up", int'(o_level_up), e.lup);
        chk("frog_reset", int'(o_frog_reset), (e.col | e.lup));
        cur_lives = e.lives;
        cur_level = e.level;
        cur_go    = e.go;
      end else begin
        chk("idle_collision", int'(o_collision), 0);
        chk("idle_level_up", int'(o_level_up), 0);
        chk("idle_frog_reset", int'(o_frog_reset), 0);
      end
      chk("lives", int'(o_lives), cur_lives);
      chk("level", int'(o_level), cur_level);
      chk("game_over", int'(o_game_over), cur_go);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog timeout at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    car_x = '{0, 100, 500, 600};
    car_y = '{0, 64, 128, 300};
    frog_x = 300; frog_y = 200;
    apply_pos();
    step(1);
    do_reset();
    step(2);

    // Scenario 1: no overlap, no goal
    issue_tick();
    step(8);

    // Scenario 2: hit, ignored tick during holdoff, accepted tick afterwards
    frog_x = 100; frog_y = 64; car_x[1] = 120; car_y[1] = 80;
    issue_tick();
    step(7);
    issue_tick();
    wait_free();
    frog_x = 300; frog_y = 200;
    issue_tick();
    step(8);

    // Scenario 3: edge abutment and right-edge wrap check
    frog_x = 100; frog_y = 64; car_x[1] = 132; car_y[1] = 64;
    issue_tick();
    wait_free();
    car_x[1] = 131;
    issue_tick();
    wait_free();
    do_reset();
    frog_x = 1000; frog_y = 64; car_x[1] = 1000; car_y[1] = 64;
    issue_tick();
    wait_free();

    // Scenario 4: ten goals, level saturates at 9
    do_reset();
    frog_x = 50; frog_y = 0; car_x[1] = 700; car_y[1] = 500;
    for (int i = 0; i < 10; i++) begin
      issue_tick();
      wait_free();
    end

    // Scenario 5: goal and overlap together -> collision only
    car_x[0] = 40; car_y[0] = 10;
    issue_tick();
    wait_free();

    // Scenario 6: drain lives, ticks in game over, reset in game over and in scan
    car_x[0] = 0; car_y[0] = 0;
    frog_x = 100; frog_y = 64; car_x[1] = 120; car_y[1] = 80;
    issue_tick();
    wait_free();
    issue_tick();
    step(LAT + 3);
    for (int i = 0; i < 3; i++) begin
      issue_tick();
      step(3);
    end
    do_reset();
    step(2);
    issue_tick();
    step(1);
    do_reset();
    step(3);

    // Randomized frames, with ticks often landing while busy
    for (int it = 0; it < 250; it++) begin
      frog_x = $urandom_range(0, 1023);
      frog_y = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 1023);
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          car_x[i] = near(frog_x);
          car_y[i] = near(frog_y);
        end else begin
          car_x[i] = $urandom_range(0, 1023);
          car_y[i] = $urandom_range(0, 1023);
        end
      end
      issue_tick();
      if ($urandom_range(0, 2) == 0) begin
        scramble();
        step(2);
        scramble();
      end
      step($urandom_range(1, 12));
      if (m_go != 0 || $urandom_range(0, 40) == 0) begin
        do_reset();
      end
    end

    step(INV + LAT + 10);
    chk("queue_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frog_collision_ctrl.md
Name: frog_collision_ctrl

Overview:
- Consumer side of the car controllers' position outputs, and the producer of the `level` value that those controllers consume.
- Once per frame it snapshots every car position and the frog position, then scans the cars one per clock with an axis-aligned overlap test.
- It resolves hit or goal events and maintains the lives count, the level and the game-over state.
- Sits between the car_ctrl instances, the frog movement logic and the VGA/score display.

Parameters:
- NUM_CARS, 4, number of car position inputs; legal range 1..8.
- CAR_W, 32, car bounding-box width in pixels.
- CAR_H, 32, car bounding-box height in pixels.
- FROG_W, 32, frog bounding-box width in pixels.
- FROG_H, 32, frog bounding-box height in pixels.
- START_LIVES, 3, lives loaded at reset; legal range 1..3.
- MAX_LEVEL, 9, highest level; level saturates here.
- GOAL_Y, 0, the frog has reached the goal when frogY <= GOAL_Y.
- INVULN_CYCLES, 24'd12_500_000, hold-off length after a hit, in clocks (0.5 s at 25 MHz).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_frame_tick  in  1  one-cycle pulse at frame start; requests a scan.
- i_carX_bus  in  10*NUM_CARS  car X positions; car n occupies bits [10n+9:10n].
- i_carY_bus  in  10*NUM_CARS  car Y positions; same packing as i_carX_bus.
- i_frogX  in  10  frog top-left X.
- i_frogY  in  10  frog top-left Y.
- o_collision  out  1  one-cycle pulse when a hit is accepted.
- o_level_up  out  1  one-cycle pulse when the goal is reached.
- o_frog_reset  out  1  one-cycle pulse telling the frog logic to return to its start position.
- o_level  out  4  current level, 4'd1..MAX_LEVEL; drives car_ctrl `level`.
- o_lives  out  2  remaining lives.
- o_game_over  out  1  sticky flag, set when lives reach 0.
- o_busy  out  1  high in any state other than IDLE and GAME_OVER.

Behaviour:
Reset values, applied on any clock with i_Rst=1, including mid-scan or mid-holdoff:
- state=IDLE, o_level=1, o_lives=START_LIVES.
- All pulses 0, o_game_over=0, scan index 0, hit flag 0, holdoff counter 0.

States: IDLE, SCAN, RESOLVE, HOLDOFF, GAME_OVER.

IDLE:
- When i_frame_tick=1 at edge k: snapshot all car buses and the frog position into registers, clear the hit flag, set idx=0, go to SCAN.

SCAN:
- Edges k+1..k+NUM_CARS each evaluate car idx against the snapshot, then increment idx.
- A car overlaps the frog only when all four terms are true:
  - carX < frogX+FROG_W
  - frogX < carX+CAR_W
  - carY < frogY+FROG_H
  - frogY < carY+CAR_H
- All sums are computed at 11 bits, so there is no wrap; the comparisons are unsigned.
- Any overlap sets the sticky hit flag.
- After car NUM_CARS-1 the state moves to RESOLVE.

RESOLVE (one cycle; outputs registered, visible after edge k+NUM_CARS+1):
- A hit has priority over the goal.
- If the hit flag is set:
  - o_collision=1 and o_frog_reset=1 for one cycle; o_lives decrements by 1.
  - If the new lives value is 0: o_game_over=1 and go to GAME_OVER.
  - Otherwise load the holdoff counter and go to HOLDOFF.
- Else, if snapshot frogY <= GOAL_Y:
  - o_level_up=1 and o_frog_reset=1 for one cycle.
  - o_level increments, saturating at MAX_LEVEL; o_level_up still pulses at saturation.
  - Lives are unchanged; go to IDLE.
- Else go to IDLE.

HOLDOFF:
- The counter counts INVULN_CYCLES clocks, then the state returns to IDLE.
- Frame ticks arriving during HOLDOFF are ignored.

GAME_OVER:
- All outputs are frozen, apart from pulses, which stay 0.
- Ticks are ignored; only i_Rst exits.

General rules:
- A frame tick arriving in SCAN, RESOLVE or HOLDOFF is dropped and is not queued.
- Car or frog input changes during SCAN have no effect, because the snapshot is used.
- Tick-to-pulse latency is fixed at NUM_CARS+1 clocks (measured from the edge that samples the tick).
- o_lives never underflows, since decrement only occurs when lives >= 1.
- Pulses never overlap: in any given cycle, at most one of o_collision or o_level_up is high.

Test Plan (NUM_CARS=4, sizes 32, INVULN_CYCLES=16 for the bench):
1. Reset; then tick with frog (300,200) and cars at (0,0),(100,64),(500,128),(600,300) -> no pulses; o_lives=3, o_level=1; o_busy high for exactly 5 cycles.
2. Frog (100,64), car1 at (120,80), tick -> o_collision and o_frog_reset pulse 5 clocks after the tick edge; o_lives=2; a tick 8 cycles later is ignored; a tick after HOLDOFF ends is accepted.
3. Edge abutment: frog (100,64), car at (132,64) -> no hit; car at (131,64) -> hit. Car at (1000,64) with frog (1000,64) -> hit, proving no 10-bit wrap.
4. Frog (50,0) with no overlaps, ten ticks -> ten o_level_up pulses; o_level goes 2,3,…,9 and stays at 9; o_lives unchanged.
5. Frog at the goal AND overlapping a car -> o_collision only; o_level unchanged; o_lives decremented.
6. Three hits -> o_lives=0, o_game_over=1, further ticks produce no pulses. Then assert i_Rst during GAME_OVER, and separately during SCAN -> next cycle state IDLE, o_lives=3, o_level=1, o_game_over=0.
